// File: rtl/parity_frame_rx_ctrl_pkg.sv
// Shared types and constants for the serial parity-frame receiver.
package parity_pkg;

  // Receiver sequencer states, in frame order.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Level of the serial line between frames; a start bit is the opposite level.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/parity_frame_rx_ctrl_xor.sv
// Even-parity check: err is 1 when the data bits plus the parity bit hold an odd number of ones.
module par_xor_reduce #(
  parameter int W = 4
) (
  input  logic [W-1:0] data,
  input  logic         pb,
  output logic         err
);

  // Pure reduction; no state.
  assign err = (^data) ^ pb;

endmodule

// File: rtl/parity_frame_rx_ctrl.sv
// Serial frame receiver: start, DATA_W data bits LSB first, even parity, stop.
// Completed frames land in a valid/ready output register; error frames are counted
// and frames completed while the register is still held are dropped and flagged.
//
// Handshake: a word is transferred on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the word is held stable.
// A frame completing in that situation is discarded and raises the sticky overrun flag.
module parity_frame_rx_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 bit_vld,
  input  logic                 bit_in,
  input  logic                 out_ready,
  input  logic                 clr_err,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_perr,
  output logic                 out_ferr,
  output logic                 busy,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_e             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     shift_q;
  logic                  pb_q;

  logic                  valid_q;
  logic [DATA_W-1:0]     data_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  ovr_q;
  logic [ERR_CNT_W-1:0]  err_q;

  logic                  perr_d;
  logic                  ferr_d;
  logic                  commit_d;
  logic                  accept_d;
  logic                  err_inc_d;

  // Parity check on the assembled word and the captured parity bit.
  par_xor_reduce #(.W(DATA_W)) u_par_xor (
    .data (shift_q),
    .pb   (pb_q),
    .err  (perr_d)
  );

  // Stop-bit evaluation: commit, whether the output register can take it, and error counting.
  always_comb begin
    ferr_d    = ~bit_in;
    commit_d  = en && bit_vld && (state_q == STOP);
    accept_d  = !valid_q || out_ready;
    err_inc_d = commit_d && (perr_d || ferr_d) && (err_q != '1);
  end

  // Sequencer, output register, overrun flag and saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      pb_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      // Disable wins over any sampled bit and throws away the partial frame.
      if (!en) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (bit_vld) begin
        unique case (state_q)
          IDLE: begin
            if (bit_in != LINE_IDLE) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end
          end
          DATA: begin
            shift_q[cnt_q] <= bit_in;
            if (cnt_q == CNT_LAST) begin
              state_q <= PARITY;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PARITY: begin
            pb_q    <= bit_in;
            state_q <= STOP;
          end
          STOP: begin
            // A bad stop bit does not wait for the line to go idle.
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end

      // A commit may reload the register in the same cycle the old word is taken.
      if (commit_d && accept_d) begin
        valid_q <= 1'b1;
        data_q  <= shift_q;
        perr_q  <= perr_d;
        ferr_q  <= ferr_d;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end

      // Clear beats a coincident overrun or error increment.
      if (clr_err) begin
        ovr_q <= 1'b0;
        err_q <= '0;
      end else begin
        if (commit_d && !accept_d) begin
          ovr_q <= 1'b1;
        end
        if (err_inc_d) begin
          err_q <= err_q + 1'b1;
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_perr  = perr_q;
  assign out_ferr  = ferr_q;
  assign overrun   = ovr_q;
  assign err_cnt   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_rx_ctrl.sv
// Bench for parity_frame_rx_ctrl: directed frames followed by randomized traffic,
// checked by a frame-level reference model and an expected-word queue.
module tb_parity_frame_rx_ctrl;

  localparam int DATA_W    = 4;
  localparam int ERR_CNT_W = 2;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;
  localparam int FRAME_LEN = DATA_W + 3;

  localparam int K_IDLE  = 0;
  localparam int K_START = 1;
  localparam int K_MID   = 2;
  localparam int K_STOP  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic bit_vld;
  logic bit_in;
  logic out_ready;
  logic clr_err;

  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic                 out_perr;
  logic                 out_ferr;
  logic                 busy;
  logic                 overrun;
  logic [ERR_CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  parity_frame_rx_ctrl #(
    .DATA_W    (DATA_W),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bit_vld   (bit_vld),
    .bit_in    (bit_in),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_perr  (out_perr),
    .out_ferr  (out_ferr),
    .busy      (busy),
    .overrun   (overrun),
    .err_cnt   (err_cnt)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  int                kind;
  logic [DATA_W+1:0] cur_word;     // {data, perr, ferr} of the frame being sent
  bit                rand_ready;
  bit                rand_clr;
  bit                clr_on_stop;
  bit                abort_rst;
  bit                mon_en;

  logic [DATA_W+1:0] exp_q[$];
  bit                m_valid;
  bit                m_ovr;
  bit                m_busy;
  int                m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: a stop bit sent with en=1 completes a frame; the output
  // register takes it if empty or being drained, otherwise it is lost.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_busy  = 1'b0;
      m_err   = 0;
      exp_q.delete();
    end else begin
      bit nv;
      nv = m_valid && !out_ready;
      if (en && bit_vld && kind == K_STOP) begin
        if (!m_valid || out_ready) begin
          exp_q.push_back(cur_word);
          nv = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        if (cur_word[1:0] != 2'b00 && m_err < ERR_MAX) m_err++;
      end
      m_valid = nv;
      if (clr_err) begin
        m_err = 0;
        m_ovr = 1'b0;
      end
      if (!en) m_busy = 1'b0;
      else if (bit_vld && kind == K_START) m_busy = 1'b1;
      else if (bit_vld && kind == K_STOP) m_busy = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_busy));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected actual=%0h expected=none at %0t",
                   {out_data, out_perr, out_ferr}, $time);
        end else begin
          chk("word", 32'({out_data, out_perr, out_ferr}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    if (rand_clr)   clr_err   = ($urandom_range(0, 15) == 0);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) begin
      bit_vld = 1'b1;
      bit_in  = 1'b1;
      kind    = K_IDLE;
      cyc();
    end
    bit_vld = 1'b0;
  endtask

  // abort_at: bit index (0=start .. FRAME_LEN-1=stop) replaced by an en drop
  // (or reset when abort_rst is set); -1 sends the whole frame.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic pb, input logic sb,
                            input int gmax, input int abort_at);
    logic [FRAME_LEN-1:0] bits;
    bit                   done;
    bits     = {sb, pb, d, 1'b0};
    cur_word = {d, (^d) ^ pb, ~sb};
    done     = 1'b0;
    for (int i = 0; i < FRAME_LEN && !done; i++) begin
      repeat ($urandom_range(0, gmax)) begin
        bit_vld = 1'b0;
        bit_in  = 1'($urandom_range(0, 1));
        kind    = K_IDLE;
        cyc();
      end
      if (i == abort_at) begin
        bit_vld = 1'($urandom_range(0, 1));
        bit_in  = 1'($urandom_range(0, 1));
        kind    = K_IDLE;
        if (abort_rst) rst_n = 1'b0;
        else           en    = 1'b0;
        cyc();
        rst_n = 1'b1;
        en    = 1'b1;
        done  = 1'b1;
      end else begin
        bit_vld = 1'b1;
        bit_in  = bits[i];
        kind    = (i == 0) ? K_START : (i == FRAME_LEN - 1) ? K_STOP : K_MID;
        if (kind == K_STOP && clr_on_stop) clr_err = 1'b1;
        cyc();
        if (kind == K_STOP && clr_on_stop) clr_err = 1'b0;
      end
      bit_vld = 1'b0;
      kind    = K_IDLE;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    en          = 1'b1;
    bit_vld     = 1'b0;
    bit_in      = 1'b1;
    out_ready   = 1'b1;
    clr_err     = 1'b0;
    kind        = K_IDLE;
    cur_word    = '0;
    rand_ready  = 1'b0;
    rand_clr    = 1'b0;
    clr_on_stop = 1'b0;
    abort_rst   = 1'b0;
    mon_en      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);

    // Good frame, consumer always ready.
    send_frame(4'b1010, 1'b0, 1'b1, 0, -1);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), 32'h0a);
    chk("t1_perr", 32'(out_perr), 0);
    chk("t1_ferr", 32'(out_ferr), 0);
    chk("t1_err_cnt", 32'(err_cnt), 0);
    cyc();

    // Parity error, then framing error.
    send_frame(4'b0001, 1'b0, 1'b1, 0, -1);
    chk("t2a_perr", 32'(out_perr), 1);
    chk("t2a_err_cnt", 32'(err_cnt), 1);
    send_frame(4'b0001, 1'b1, 1'b0, 0, -1);
    chk("t2b_perr", 32'(out_perr), 0);
    chk("t2b_ferr", 32'(out_ferr), 1);
    chk("t2b_err_cnt", 32'(err_cnt), 2);
    cyc();

    // Consumer stalled: second frame is dropped and flagged.
    out_ready = 1'b0;
    send_frame(4'b0011, 1'b0, 1'b1, 0, -1);
    send_frame(4'b0101, 1'b0, 1'b1, 0, -1);
    chk("t3_data_held", 32'(out_data), 32'h3);
    chk("t3_overrun", 32'(overrun), 1);
    out_ready = 1'b1;
    cyc();
    chk("t3_valid_drop", 32'(out_valid), 0);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("t3_overrun_clr", 32'(overrun), 0);

    // Disable after two data bits, then a clean frame.
    send_frame(4'b0110, 1'b0, 1'b1, 0, 3);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_valid", 32'(out_valid), 0);
    send_frame(4'b1100, 1'b0, 1'b1, 0, -1);
    chk("t4_data", 32'(out_data), 32'hc);
    chk("t4_perr", 32'(out_perr), 0);
    cyc();

    // Reset while waiting for the parity bit, with a word held and errors counted.
    out_ready = 1'b0;
    send_frame(4'b0111, 1'b0, 1'b0, 0, -1);
    abort_rst = 1'b1;
    send_frame(4'b0101, 1'b0, 1'b1, 0, DATA_W + 1);
    abort_rst = 1'b0;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_perr", 32'(out_perr), 0);
    chk("t5_ferr", 32'(out_ferr), 0);
    chk("t5_err_cnt", 32'(err_cnt), 0);
    out_ready = 1'b1;
    send_frame(4'b1001, 1'b0, 1'b1, 0, -1);
    chk("t5_data_after", 32'(out_data), 32'h9);
    chk("t5_flags_after", 32'({out_perr, out_ferr}), 0);
    cyc();

    // Saturation, then clear coinciding with a bad commit.
    repeat (5) send_frame(4'b0001, 1'b0, 1'b1, 0, -1);
    chk("t6_err_sat", 32'(err_cnt), ERR_MAX);
    clr_on_stop = 1'b1;
    send_frame(4'b0001, 1'b0, 1'b1, 0, -1);
    clr_on_stop = 1'b0;
    chk("t6_err_clr", 32'(err_cnt), 0);
    cyc();

    // Randomized traffic: gaps, back-to-back frames, stalls, clears, aborts.
    rand_ready = 1'b1;
    rand_clr   = 1'b1;
    for (int f = 0; f < 300; f++) begin
      logic [DATA_W-1:0] d;
      logic              pb;
      logic              sb;
      int                ab;
      d  = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 7) != 0);
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, FRAME_LEN - 1)) : -1;
      idle_bits(int'($urandom_range(0, 2)));
      send_frame(d, pb, sb, 2, ab);
    end

    rand_ready = 1'b0;
    rand_clr   = 1'b0;
    out_ready  = 1'b1;
    clr_err    = 1'b0;
    bit_vld    = 1'b0;
    repeat (3) cyc();
    chk("drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
